// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared CPU package: stall-controller FSM states and MD timing default.
package pipe_stall_ctrl_pkg;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MD_WAIT = 1'b1
   } stall_state_e;

   // Total execute cycles of a multiply/divide op (legal range 2..16).
   localparam int unsigned MD_CYCLES_DEF = 4;

endpackage

// File: rtl/md_cycle_timer.sv
// Down-counter timing the remaining cycles of a multi-cycle MD op.
// Load wins over decrement; the count never wraps below zero.
module md_cycle_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] cnt_q, cnt_d;

   // Next count: load a fresh value or step down by one.
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (dec && (cnt_q != 4'd0))
         cnt_d = cnt_q - 4'd1;
   end

   // Count register, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 4'd0;
      else     cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: memory freeze, multi-cycle MD stall,
// branch redirect flush and load-use bubble.
// Optional: define STALL_COUNT_EN to add the stall_cycles counter output.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned MD_CYCLES = MD_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bubble,
   input  logic        jb_taken,
   input  logic        md_req,
   input  logic        dmem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        idex_en,
   output logic        exmem_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        md_busy,
`ifdef STALL_COUNT_EN
   output logic        md_done,
   output logic [31:0] stall_cycles
`else
   output logic        md_done
`endif
);

   // The entry cycle counts as the first of MD_CYCLES, the zero-count
   // cycle as the last, so the timer starts at MD_CYCLES-2.
   localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 2);

   stall_state_e state_q, state_d;
   logic         tmr_load, tmr_dec, md_zero;

   md_cycle_timer u_md_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (MD_LOAD),
      .dec      (tmr_dec),
      .zero     (md_zero)
   );

   // Next state and outputs, highest priority first: reset, freeze,
   // MD wait, MD entry, redirect, bubble, normal.
   always_comb begin
      state_d    = state_q;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      md_busy    = 1'b0;
      md_done    = 1'b0;
      if (rst) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (!dmem_ready) begin
         // Everything holds; an in-flight MD op is still busy.
         md_busy = (state_q == ST_MD_WAIT);
      end else if (state_q == ST_MD_WAIT) begin
         md_busy = 1'b1;
         if (md_zero) begin
            md_done  = 1'b1;
            exmem_en = 1'b1;
            state_d  = ST_RUN;
         end else begin
            tmr_dec = 1'b1;
         end
      end else if (md_req) begin
         md_busy  = 1'b1;
         tmr_load = 1'b1;
         state_d  = ST_MD_WAIT;
      end else if (jb_taken) begin
         pc_en      = 1'b1;
         ifid_en    = 1'b1;
         idex_en    = 1'b1;
         exmem_en   = 1'b1;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (bubble) begin
         idex_en    = 1'b1;
         exmem_en   = 1'b1;
         idex_flush = 1'b1;
      end else begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         idex_en  = 1'b1;
         exmem_en = 1'b1;
      end
   end

   // State register; reset drops any in-flight MD op back to RUN.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

`ifdef STALL_COUNT_EN
   logic [31:0] stall_q, stall_d;

   // Saturating count of cycles where the PC did not advance.
   always_comb begin
      stall_d = stall_q;
      if (!pc_en && (stall_q != 32'hFFFF_FFFF))
         stall_d = stall_q + 32'd1;
   end

   // Stall counter register, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) stall_q <= 32'd0;
      else     stall_q <= stall_d;
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl (MD_CYCLES=4): a cycle-by-cycle vector
// table plus hand-written MD-length and stall-counter sequences.
module tb_pipe_stall_ctrl;

   logic clk, rst, bubble, jb_taken, md_req, dmem_ready;
   logic pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, md_busy, md_done;
`ifdef STALL_COUNT_EN
   logic [31:0] stall_cycles;
`endif

   int total = 0;
   int passed = 0;

   pipe_stall_ctrl #(.MD_CYCLES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .bubble     (bubble),
      .jb_taken   (jb_taken),
      .md_req     (md_req),
      .dmem_ready (dmem_ready),
      .pc_en      (pc_en),
      .ifid_en    (ifid_en),
      .idex_en    (idex_en),
      .exmem_en   (exmem_en),
      .ifid_flush (ifid_flush),
      .idex_flush (idex_flush),
      .md_busy    (md_busy),
`ifdef STALL_COUNT_EN
      .md_done    (md_done),
      .stall_cycles (stall_cycles)
`else
      .md_done    (md_done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // in  = {rst, bubble, jb_taken, md_req, dmem_ready}
   // exp = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, md_busy, md_done}
   typedef struct {
      logic [4:0] in;
      logic [7:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   // Drive one cycle's inputs at the falling edge and let them settle.
   task automatic drive(input logic [4:0] in);
      @(negedge clk);
      {rst, bubble, jb_taken, md_req, dmem_ready} = in;
      #1;
   endtask

   function automatic logic [7:0] outs();
      return {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, md_busy, md_done};
   endfunction

   initial begin
      int n_stall, n_done;
      logic seen;
      {rst, bubble, jb_taken, md_req, dmem_ready} = 5'b10001;

      vecs.push_back('{5'b10001, 8'b0000_1100, "reset"});
      vecs.push_back('{5'b11101, 8'b0000_1100, "reset_ign_in"});
      vecs.push_back('{5'b00001, 8'b1111_0000, "normal"});
      vecs.push_back('{5'b01001, 8'b0011_0100, "bubble"});
      vecs.push_back('{5'b00001, 8'b1111_0000, "after_bubble"});
      vecs.push_back('{5'b00101, 8'b1111_1100, "jb"});
      vecs.push_back('{5'b01101, 8'b1111_1100, "jb_bubble"});
      vecs.push_back('{5'b01000, 8'b0000_0000, "freeze_bubble"});
      vecs.push_back('{5'b00010, 8'b0000_0000, "freeze_mdreq"});
      // MD op, 4 cycles
      vecs.push_back('{5'b00011, 8'b0000_0010, "md_entry"});
      vecs.push_back('{5'b00011, 8'b0000_0010, "md_wait2"});
      vecs.push_back('{5'b01111, 8'b0000_0010, "md_wait1_ign"});
      vecs.push_back('{5'b00011, 8'b0001_0011, "md_done"});
      vecs.push_back('{5'b00001, 8'b1111_0000, "md_back_run"});
      // MD op frozen 2 cycles mid-wait: 6 cycles
      vecs.push_back('{5'b00011, 8'b0000_0010, "mdf_entry"});
      vecs.push_back('{5'b00011, 8'b0000_0010, "mdf_wait2"});
      vecs.push_back('{5'b00010, 8'b0000_0010, "mdf_frz1"});
      vecs.push_back('{5'b00010, 8'b0000_0010, "mdf_frz2"});
      vecs.push_back('{5'b00011, 8'b0000_0010, "mdf_wait1"});
      vecs.push_back('{5'b00011, 8'b0001_0011, "mdf_done"});
      vecs.push_back('{5'b00001, 8'b1111_0000, "mdf_back_run"});
      // MD entry ignoring jb/bubble; freeze on the final count
      vecs.push_back('{5'b01111, 8'b0000_0010, "mdz_entry_ign"});
      vecs.push_back('{5'b00011, 8'b0000_0010, "mdz_wait2"});
      vecs.push_back('{5'b00011, 8'b0000_0010, "mdz_wait1"});
      vecs.push_back('{5'b00010, 8'b0000_0010, "mdz_frz_at0"});
      vecs.push_back('{5'b00011, 8'b0001_0011, "mdz_done"});
      vecs.push_back('{5'b00001, 8'b1111_0000, "mdz_back_run"});
      // Reset in the 2nd MD_WAIT cycle aborts the op
      vecs.push_back('{5'b00011, 8'b0000_0010, "mdr_entry"});
      vecs.push_back('{5'b00011, 8'b0000_0010, "mdr_wait2"});
      vecs.push_back('{5'b10011, 8'b0000_1100, "mdr_reset"});
      vecs.push_back('{5'b00001, 8'b1111_0000, "mdr_after_rst"});
      vecs.push_back('{5'b00001, 8'b1111_0000, "mdr_no_done"});

      foreach (vecs[i]) begin
         drive(vecs[i].in);
         chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      end

      // MD op length measured from the outside, bounded wait for md_done.
      drive(5'b10001);
      n_stall = 0; n_done = 0; seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         drive((i == 0) ? 5'b00011 : 5'b00001);
         if (!pc_en) n_stall++;
         if (md_done) begin n_done++; seen = 1'b1; end
      end
      chk("md_seen_done", 32'(seen), 32'd1);
      chk("md_stall_len", 32'(n_stall), 32'd4);
      drive(5'b00001);
      chk("md_post_pc_en", 32'(pc_en), 32'd1);
      chk("md_post_done", 32'(md_done), 32'd0);

`ifdef STALL_COUNT_EN
      drive(5'b10001);
      drive(5'b00001);
      chk("stall_cleared", stall_cycles, 32'd0);
      drive(5'b01001); drive(5'b00001);
      drive(5'b01001); drive(5'b00001);
      drive(5'b01001); drive(5'b00001);
      drive(5'b00011); drive(5'b00001); drive(5'b00001); drive(5'b00001);
      drive(5'b00001);
      chk("stall_count", stall_cycles, 32'd7);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
